// File: rtl/fp32_align_stage_if.sv
// fp32_align_stage_if: operand channel in, aligned-operand channel out, each with valid/ready.
interface fp32_align_stage_if;
   localparam int unsigned DataW = 32;
   localparam int unsigned ExpW  = 8;

   logic             in_valid;
   logic             in_ready;
   logic [DataW-1:0] op_a;
   logic [DataW-1:0] op_b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [DataW-1:0] mant0;
   logic [DataW-1:0] mant1;
   logic             carry_in;
   logic [ExpW-1:0]  exp_out;
   logic             sign_out;
   logic             nan_out;
   logic             inf_out;

   modport master (
      output in_valid, op_a, op_b, sub, out_ready,
      input  in_ready, out_valid, mant0, mant1, carry_in, exp_out, sign_out, nan_out, inf_out
   );

   modport slave (
      input  in_valid, op_a, op_b, sub, out_ready,
      output in_ready, out_valid, mant0, mant1, carry_in, exp_out, sign_out, nan_out, inf_out
   );
endinterface

// File: rtl/fp32_align_stage.sv
// fp32_align_stage: two-stage binary32 add/sub operand swap, alignment and special-case flagging.
// Define FP_ALIGN_STICKY_EN to fold shifted-out bits into the sticky position (bit 3).
module fp32_align_stage (
   input logic               clk,
   input logic               rst,
   fp32_align_stage_if.slave bus
);
   localparam int unsigned ExpW  = 8;
   localparam int unsigned FracW = 23;
   localparam int unsigned MantW = 32;
   localparam int unsigned ShW   = 5;
   localparam logic [ExpW-1:0] ExpMax = '1;

   logic             s1_valid_q, s1_valid_d;
   logic             out_valid_q, out_valid_d;
   logic             s2_ready_c, in_ready_c, accept_c;

   logic [MantW-1:0] big_q, big_d;
   logic [MantW-1:0] small_q, small_d;
   logic [ShW-1:0]   shift_q, shift_d;
   logic [ExpW-1:0]  exp_q, exp_d;
   logic             eff_sub_q, eff_sub_d;
   logic             sign_q, sign_d;
   logic             nan_q, nan_d;
   logic             inf_q, inf_d;

   logic [MantW-1:0] mant0_q, mant0_d;
   logic [MantW-1:0] mant1_q, mant1_d;
   logic [ExpW-1:0]  exp_out_q, exp_out_d;
   logic             carry_q, carry_d;
   logic             sign_out_q, sign_out_d;
   logic             nan_out_q, nan_out_d;
   logic             inf_out_q, inf_out_d;

   logic [ExpW-1:0]  ea, eb, ea_adj, eb_adj, e_big, e_small, e_diff;
   logic [FracW-1:0] fa, fb;
   logic             sa, sb_eff, eff_sub_c, a_big, mag_eq;
   logic             a_nan, b_nan, a_inf, b_inf;
   logic [MantW-1:0] aligned;
`ifdef FP_ALIGN_STICKY_EN
   logic [2*MantW-1:0] wide;
   logic               sticky;
`endif

   // Elastic handshake: each stage loads when its downstream is empty or draining
   always_comb begin
      s2_ready_c  = ~out_valid_q | bus.out_ready;
      in_ready_c  = ~s1_valid_q | s2_ready_c;
      accept_c    = bus.in_valid & in_ready_c;
      s1_valid_d  = in_ready_c ? accept_c : s1_valid_q;
      out_valid_d = s2_ready_c ? s1_valid_q : out_valid_q;
   end

   // S1: classify, order by magnitude, compute shift and result exponent/sign/flags
   always_comb begin
      sa        = bus.op_a[31];
      sb_eff    = bus.op_b[31] ^ bus.sub;
      eff_sub_c = sa ^ sb_eff;
      ea        = bus.op_a[30:23];
      eb        = bus.op_b[30:23];
      fa        = bus.op_a[22:0];
      fb        = bus.op_b[22:0];
      ea_adj    = (ea == '0) ? ExpW'(1) : ea;
      eb_adj    = (eb == '0) ? ExpW'(1) : eb;
      a_big     = bus.op_a[30:0] >= bus.op_b[30:0];
      mag_eq    = bus.op_a[30:0] == bus.op_b[30:0];
      e_big     = a_big ? ea_adj : eb_adj;
      e_small   = a_big ? eb_adj : ea_adj;
      e_diff    = e_big - e_small;
      a_nan     = (ea == ExpMax) && (fa != '0);
      b_nan     = (eb == ExpMax) && (fb != '0);
      a_inf     = (ea == ExpMax) && (fa == '0);
      b_inf     = (eb == ExpMax) && (fb == '0);

      big_d     = a_big ? {2'b00, |ea, fa, 6'b000000} : {2'b00, |eb, fb, 6'b000000};
      small_d   = a_big ? {2'b00, |eb, fb, 6'b000000} : {2'b00, |ea, fa, 6'b000000};
      shift_d   = (e_diff > ExpW'(31)) ? '1 : e_diff[ShW-1:0];
      exp_d     = e_big;
      eff_sub_d = eff_sub_c;
      // Exact cancellation always yields +0
      sign_d    = (eff_sub_c && mag_eq) ? 1'b0 : (a_big ? sa : sb_eff);
      nan_d     = a_nan | b_nan | (a_inf & b_inf & eff_sub_c);
      inf_d     = (a_inf | b_inf) & ~nan_d;
   end

   // S2: align the smaller mantissa, then invert for effective subtraction
   always_comb begin
`ifdef FP_ALIGN_STICKY_EN
      wide    = {small_q, MantW'(0)} >> shift_q;
      sticky  = |wide[MantW+3:0];
      aligned = {wide[2*MantW-1:MantW+4], sticky, 3'b000};
`else
      aligned = (small_q >> shift_q) & ~MantW'(15);
`endif
      mant0_d    = big_q;
      mant1_d    = eff_sub_q ? ~aligned : aligned;
      carry_d    = eff_sub_q;
      exp_out_d  = exp_q;
      sign_out_d = sign_q;
      nan_out_d  = nan_q;
      inf_out_d  = inf_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         big_q       <= '0;
         small_q     <= '0;
         shift_q     <= '0;
         exp_q       <= '0;
         eff_sub_q   <= 1'b0;
         sign_q      <= 1'b0;
         nan_q       <= 1'b0;
         inf_q       <= 1'b0;
         mant0_q     <= '0;
         mant1_q     <= '0;
         exp_out_q   <= '0;
         carry_q     <= 1'b0;
         sign_out_q  <= 1'b0;
         nan_out_q   <= 1'b0;
         inf_out_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         if (accept_c) begin
            big_q     <= big_d;
            small_q   <= small_d;
            shift_q   <= shift_d;
            exp_q     <= exp_d;
            eff_sub_q <= eff_sub_d;
            sign_q    <= sign_d;
            nan_q     <= nan_d;
            inf_q     <= inf_d;
         end
         if (s2_ready_c && s1_valid_q) begin
            mant0_q    <= mant0_d;
            mant1_q    <= mant1_d;
            exp_out_q  <= exp_out_d;
            carry_q    <= carry_d;
            sign_out_q <= sign_out_d;
            nan_out_q  <= nan_out_d;
            inf_out_q  <= inf_out_d;
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.mant0     = mant0_q;
   assign bus.mant1     = mant1_q;
   assign bus.carry_in  = carry_q;
   assign bus.exp_out   = exp_out_q;
   assign bus.sign_out  = sign_out_q;
   assign bus.nan_out   = nan_out_q;
   assign bus.inf_out   = inf_out_q;
endmodule

// File: tb/tb_fp32_align_stage.sv
// tb_fp32_align_stage: directed vectors plus randomized traffic with backpressure vs. an arithmetic model.
module tb_fp32_align_stage;
   typedef struct packed {
      logic [31:0] m0;
      logic [31:0] m1;
      logic        ci;
      logic [7:0]  e;
      logic        s;
      logic        nan;
      logic        inf;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sb;
      res_t        r;
   } vec_t;

`ifdef FP_ALIGN_STICKY_EN
   localparam logic [31:0] Stk = 32'h0000_0008;
`else
   localparam logic [31:0] Stk = 32'h0000_0000;
`endif

   logic clk = 1'b0;
   logic rst;
   logic bp_en  = 1'b0;
   logic bp_val = 1'b1;
   logic or_drv = 1'b1;
   int   total  = 0;
   int   bad    = 0;
   res_t obs_q[$];
   res_t exp_q[$];
   res_t dut_res;

   fp32_align_stage_if bus();

   fp32_align_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.out_ready = bp_en ? bp_val : or_drv;
   assign dut_res = {bus.mant0, bus.mant1, bus.carry_in, bus.exp_out,
                     bus.sign_out, bus.nan_out, bus.inf_out};

   always begin
      @(posedge clk);
      #1;
      bp_val = 1'($urandom_range(0, 1));
   end

   // Record every output transfer, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
         obs_q.push_back(dut_res);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Reference: integer significands, divide/modulo for alignment
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sb_in);
      res_t r;
      int unsigned ea, eb, ebig, esml, sh;
      longint unsigned sig_a, sig_b, big, sml, shifted;
      logic sa, sb, eff, a_wins, a_nan, b_nan, a_inf, b_inf;
      logic [31:0] v;
      sa     = a[31];
      sb     = b[31] ^ sb_in;
      eff    = sa ^ sb;
      ea     = 32'(a[30:23]);
      eb     = 32'(b[30:23]);
      sig_a  = 64'(a[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
      sig_b  = 64'(b[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
      if (ea == 0) ea = 1;
      if (eb == 0) eb = 1;
      a_wins = a[30:0] >= b[30:0];
      ebig   = a_wins ? ea : eb;
      esml   = a_wins ? eb : ea;
      big    = (a_wins ? sig_a : sig_b) * 64;
      sml    = (a_wins ? sig_b : sig_a) * 64;
      sh     = ebig - esml;
      if (sh > 31) sh = 31;
      shifted = sml >> sh;
`ifdef FP_ALIGN_STICKY_EN
      v = 32'((shifted / 16) * 16 + (((sml % (64'd1 << (sh + 3))) != 0) ? 64'd8 : 64'd0));
`else
      v = 32'((shifted / 16) * 16);
`endif
      r.m0  = 32'(big);
      r.m1  = eff ? ~v : v;
      r.ci  = eff;
      r.e   = 8'(ebig);
      r.s   = (eff && a[30:0] == b[30:0]) ? 1'b0 : (a_wins ? sa : sb);
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      r.nan = a_nan || b_nan || (a_inf && b_inf && eff);
      r.inf = (a_inf || b_inf) && !r.nan;
      return r;
   endfunction

   task automatic gen_ops(output logic [31:0] a, output logic [31:0] b, output logic s);
      int e;
      int mode;
      a    = $urandom;
      b    = $urandom;
      s    = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
         a[30:23] = 8'hFF;
         if ($urandom_range(0, 1) == 0) a[22:0] = '0;
      end else if (mode == 1) begin
         a[30:23] = 8'h00;
      end
      if (mode == 2) begin
         b = a;
      end else begin
         e = int'(a[30:23]) + int'($urandom_range(0, 80)) - 40;
         if (e < 0) e = 0;
         if (e > 255) e = 255;
         b[30:23] = 8'(e);
         if ($urandom_range(0, 5) == 0) b[22:0] = '0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      or_drv = 1'b1;
      bus.in_valid = 1'b1;
      bus.op_a = 32'h3F80_0000;
      bus.op_b = 32'h3F80_0000;
      bus.sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
      end
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
      end
      total++;
      if (dut_res !== '0) begin
         bad++; $display("FAIL reset_outputs got=%h want=0", dut_res);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_ignored_valid got=%b want=0", bus.out_valid);
      end
   endtask

   task automatic test_directed();
      vec_t v[10];
      v[0] = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, res_t'{32'h2000_0000, 32'h2000_0000, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0}};
      v[1] = '{32'h3F80_0000, 32'h3F00_0000, 1'b1, res_t'{32'h2000_0000, 32'hEFFF_FFFF, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0}};
      v[2] = '{32'h3F80_0000, 32'h3380_0001, 1'b0, res_t'{32'h2000_0000, 32'h20 | Stk,   1'b0, 8'h7F, 1'b0, 1'b0, 1'b0}};
      v[3] = '{32'h7FC0_0000, 32'h3F80_0000, 1'b0, res_t'{32'h3000_0000, Stk,           1'b0, 8'hFF, 1'b0, 1'b1, 1'b0}};
      v[4] = '{32'h7F80_0000, 32'h7F80_0000, 1'b1, res_t'{32'h2000_0000, 32'hDFFF_FFFF, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0}};
      v[5] = '{32'h7F80_0000, 32'h3F80_0000, 1'b0, res_t'{32'h2000_0000, Stk,           1'b0, 8'hFF, 1'b0, 1'b0, 1'b1}};
      v[6] = '{32'hBF80_0000, 32'h4000_0000, 1'b0, res_t'{32'h2000_0000, 32'hEFFF_FFFF, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0}};
      v[7] = '{32'h3F80_0000, 32'h4000_0000, 1'b1, res_t'{32'h2000_0000, 32'hEFFF_FFFF, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0}};
      v[8] = '{32'h0000_0001, 32'h0000_0001, 1'b0, res_t'{32'h0000_0040, 32'h0000_0040, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0}};
      v[9] = '{32'hBF80_0000, 32'hBF80_0000, 1'b1, res_t'{32'h2000_0000, 32'hDFFF_FFFF, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0}};
      or_drv = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         bus.op_a = v[i].a;
         bus.op_b = v[i].b;
         bus.sub = v[i].sb;
         bus.in_valid = 1'b1;
         @(negedge clk);
         total++;
         if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL dir%0d_in_ready got=%b want=1", i, bus.in_ready);
         end
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL dir%0d_early_valid got=%b want=0", i, bus.out_valid);
         end
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || dut_res !== v[i].r) begin
            bad++;
            $display("FAIL dir%0d_result valid=%b got=%h want=%h", i, bus.out_valid, dut_res, v[i].r);
         end
      end
      @(negedge clk);
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a[3];
      logic [31:0] b[3];
      logic        s[3];
      logic        want_rdy;
      res_t        e0, e;
      int          w;
      obs_q.delete();
      for (int i = 0; i < 3; i++) gen_ops(a[i], b[i], s[i]);
      e0 = model(a[0], b[0], s[0]);
      or_drv = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         bus.op_a = a[i];
         bus.op_b = b[i];
         bus.sub = s[i];
         bus.in_valid = 1'b1;
         want_rdy = (i < 2);
         @(negedge clk);
         total++;
         if (bus.in_ready !== want_rdy) begin
            bad++; $display("FAIL b2b_in_ready%0d got=%b want=%b", i, bus.in_ready, want_rdy);
         end
         if (i < 2) begin
            @(posedge clk);
            #1;
         end
      end
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || dut_res !== e0) begin
            bad++;
            $display("FAIL b2b_hold%0d valid=%b rdy=%b got=%h want=%h", c, bus.out_valid, bus.in_ready, dut_res, e0);
         end
      end
      @(posedge clk);
      #1;
      or_drv = 1'b1;
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL b2b_release_rdy got=%b want=1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      w = 0;
      while (obs_q.size() < 3 && w < 20) begin
         @(posedge clk);
         w++;
      end
      @(negedge clk);
      total++;
      if (obs_q.size() != 3) begin
         bad++; $display("FAIL b2b_count got=%0d want=3", obs_q.size());
      end
      for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
         e = model(a[i], b[i], s[i]);
         total++;
         if (obs_q[0] !== e) begin
            bad++; $display("FAIL b2b_txn%0d got=%h want=%h", i, obs_q[0], e);
         end
         void'(obs_q.pop_front());
      end
      obs_q.delete();
   endtask

   task automatic test_reset_flush();
      logic [31:0] a, b;
      logic        s;
      obs_q.delete();
      or_drv = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         gen_ops(a, b, s);
         bus.op_a = a;
         bus.op_b = b;
         bus.sub = s;
         bus.in_valid = 1'b1;
         @(negedge clk);
         total++;
         if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_fill%0d got=%b want=1", i, bus.in_ready);
         end
         @(posedge clk);
         #1;
      end
      gen_ops(a, b, s);
      bus.op_a = a;
      bus.op_b = b;
      bus.sub = s;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      or_drv = 1'b1;
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL flush_state valid=%b rdy=%b want valid=0 rdy=1", bus.out_valid, bus.in_ready);
      end
      total++;
      if (dut_res !== '0) begin
         bad++; $display("FAIL flush_outputs got=%h want=0", dut_res);
      end
      repeat (6) @(negedge clk);
      total++;
      if (obs_q.size() != 0) begin
         bad++; $display("FAIL flush_leak got=%0d transfers want=0", obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_random(input int n_txn);
      logic [31:0] a, b;
      logic        s;
      int          w;
      res_t        o, e;
      obs_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      bp_en = 1'b1;
      for (int i = 0; i < n_txn; i++) begin
         gen_ops(a, b, s);
         bus.op_a = a;
         bus.op_b = b;
         bus.sub = s;
         bus.in_valid = 1'b1;
         w = 0;
         @(negedge clk);
         while (bus.in_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (w >= 100) begin
            total++; bad++;
            $display("FAIL rand_accept_timeout txn=%0d got in_ready=%b want=1", i, bus.in_ready);
            break;
         end
         exp_q.push_back(model(a, b, s));
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      bp_en = 1'b0;
      w = 0;
      while (obs_q.size() < exp_q.size() && w < 200) begin
         @(posedge clk);
         w++;
      end
      @(negedge clk);
      total++;
      if (obs_q.size() != exp_q.size()) begin
         bad++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total++;
         if (o !== e) begin
            bad++; $display("FAIL rand_txn got=%h want=%h", o, e);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.sub = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_flush();
      test_random(300);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
